// File: rtl/fp_norm_pkg.sv
// rtl/fp_norm_pkg.sv - shared constants, flag indices and FSM state type for fp_normalize_round
package fp_norm_pkg;

    localparam int EXP_W     = 8;
    localparam int FRAC_W    = 23;
    localparam int MAX_SHIFT = 23;
    localparam int EXP_MAX   = 255;
    localparam int BIAS      = 127;

    // Bit positions inside out_flags when FP_NORM_STATUS_EN is defined
    localparam int FLAG_INEXACT   = 3;
    localparam int FLAG_OVERFLOW  = 2;
    localparam int FLAG_UNDERFLOW = 1;
    localparam int FLAG_ZERO      = 0;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CHECK,
        ST_SHIFT,
        ST_ROUND,
        ST_DONE
    } state_e;

endpackage

// File: rtl/fp_round_rne.sv
// rtl/fp_round_rne.sv - combinational round-to-nearest-even on a normalised mantissa
module fp_round_rne #(
    parameter int EXP_W  = 8,
    parameter int FRAC_W = 23
) (
    input  logic [FRAC_W:0] mant_i,
    input  logic            g_i,
    input  logic            r_i,
    input  logic            s_i,
    input  logic [EXP_W:0]  exp_i,
    output logic [FRAC_W:0] mant_o,
    output logic [EXP_W:0]  exp_o,
    output logic            overflow_o,
    output logic            inexact_o
);

    localparam logic [EXP_W:0] EXP_ALL_ONES = (EXP_W + 1)'((1 << EXP_W) - 1);

    logic              inc;
    logic [FRAC_W+1:0] sum;

    always_comb begin
        inc       = g_i & (r_i | s_i | mant_i[0]);
        sum       = {1'b0, mant_i} + (FRAC_W + 2)'(inc);
        inexact_o = g_i | r_i | s_i;
        // A carry out of the increment means 1.111..1 rounded up to 10.000..0
        if (sum[FRAC_W+1]) begin
            mant_o = {1'b1, {FRAC_W{1'b0}}};
            exp_o  = exp_i + (EXP_W + 1)'(1);
        end else begin
            mant_o = sum[FRAC_W:0];
            exp_o  = exp_i;
        end
        overflow_o = (exp_o >= EXP_ALL_ONES);
    end

endmodule

// File: rtl/fp_normalize_round.sv
// rtl/fp_normalize_round.sv - iterative normalise, RNE round and binary32 pack; optional out_flags via FP_NORM_STATUS_EN
module fp_normalize_round
    import fp_norm_pkg::*;
#(
    parameter int EXP_W     = fp_norm_pkg::EXP_W,
    parameter int FRAC_W    = fp_norm_pkg::FRAC_W,
    parameter int MAX_SHIFT = fp_norm_pkg::MAX_SHIFT
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic                      in_sign,
    input  logic [EXP_W-1:0]          in_exp,
    input  logic [FRAC_W+1:0]         in_mant,
    input  logic [2:0]                in_grs,
    output logic                      out_valid,
    input  logic                      out_ready,
`ifdef FP_NORM_STATUS_EN
    output logic [3:0]                out_flags,
`endif
    output logic [EXP_W+FRAC_W:0]     out_result
);

    localparam int MW = FRAC_W + 2;
    localparam int EW = EXP_W + 1;
    localparam int RW = EXP_W + FRAC_W + 1;
    localparam int CW = $clog2(MAX_SHIFT + 2);
    localparam logic [EW-1:0] EXP_ALL_ONES = EW'((1 << EXP_W) - 1);

    state_e          state_q, state_d;
    logic            sign_q, sign_d;
    logic [EW-1:0]   exp_q, exp_d;
    logic [MW-1:0]   mant_q, mant_d;
    logic            g_q, g_d, r_q, r_d, s_q, s_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [RW-1:0]   result_q, result_d;
    logic            valid_q, valid_d;
`ifdef FP_NORM_STATUS_EN
    logic [3:0]      flags_q, flags_d;
`endif

    logic [MW-1:0]   mant_shl;
    logic [FRAC_W:0] rnd_mant;
    logic [EXP_W:0]  rnd_exp;
    logic            rnd_ovf, rnd_inexact;

    fp_round_rne #(.EXP_W(EXP_W), .FRAC_W(FRAC_W)) u_round (
        .mant_i     (mant_q[FRAC_W:0]),
        .g_i        (g_q),
        .r_i        (r_q),
        .s_i        (s_q),
        .exp_i      (exp_q),
        .mant_o     (rnd_mant),
        .exp_o      (rnd_exp),
        .overflow_o (rnd_ovf),
        .inexact_o  (rnd_inexact)
    );

    assign in_ready   = (state_q == ST_IDLE) && !rst;
    assign out_valid  = valid_q;
    assign out_result = result_q;
`ifdef FP_NORM_STATUS_EN
    assign out_flags  = flags_q;
`endif

    always_comb begin
        state_d  = state_q;
        sign_d   = sign_q;
        exp_d    = exp_q;
        mant_d   = mant_q;
        g_d      = g_q;
        r_d      = r_q;
        s_d      = s_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        valid_d  = valid_q;
`ifdef FP_NORM_STATUS_EN
        flags_d  = flags_q;
`endif
        mant_shl = {mant_q[MW-2:0], g_q};

        case (state_q)
            ST_IDLE: begin
                if (in_valid && in_ready) begin
                    sign_d  = in_sign;
                    exp_d   = {1'b0, in_exp};
                    mant_d  = in_mant;
                    {g_d, r_d, s_d} = in_grs;
                    cnt_d   = '0;
                    state_d = ST_CHECK;
`ifdef FP_NORM_STATUS_EN
                    flags_d = '0;
`endif
                end
            end
            ST_CHECK: begin
                if (exp_q == EXP_ALL_ONES) begin
                    result_d = {sign_q, {EXP_W{1'b1}}, {FRAC_W{1'b0}}};
                    state_d  = ST_DONE;
                end else if (mant_q == '0 && {g_q, r_q, s_q} == 3'b000) begin
                    result_d = {sign_q, {(RW-1){1'b0}}};
                    state_d  = ST_DONE;
`ifdef FP_NORM_STATUS_EN
                    flags_d[FLAG_ZERO] = 1'b1;
`endif
                end else if (mant_q[MW-1]) begin
                    mant_d  = mant_q >> 1;
                    exp_d   = exp_q + EW'(1);
                    g_d     = mant_q[0];
                    r_d     = g_q;
                    s_d     = r_q | s_q;
                    state_d = ST_ROUND;
                end else if (mant_q[MW-2]) begin
                    state_d = ST_ROUND;
                end else begin
                    state_d = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                // Shifting at exp==1 would land on exponent 0: no denormals, flush instead
                if (exp_q <= EW'(1) || cnt_q > CW'(MAX_SHIFT)) begin
                    result_d = {sign_q, {(RW-1){1'b0}}};
                    state_d  = ST_DONE;
`ifdef FP_NORM_STATUS_EN
                    flags_d[FLAG_UNDERFLOW] = 1'b1;
                    flags_d[FLAG_ZERO]      = 1'b1;
`endif
                end else begin
                    mant_d = mant_shl;
                    g_d    = r_q;
                    r_d    = 1'b0;
                    exp_d  = exp_q - EW'(1);
                    cnt_d  = cnt_q + CW'(1);
                    if (mant_shl[MW-2]) begin
                        state_d = ST_ROUND;
                    end
                end
            end
            ST_ROUND: begin
                mant_d  = {1'b0, rnd_mant};
                exp_d   = rnd_exp;
                state_d = ST_DONE;
                if (rnd_ovf) begin
                    result_d = {sign_q, {EXP_W{1'b1}}, {FRAC_W{1'b0}}};
                end else begin
                    result_d = {sign_q, rnd_exp[EXP_W-1:0], rnd_mant[FRAC_W-1:0]};
                end
`ifdef FP_NORM_STATUS_EN
                flags_d[FLAG_INEXACT]  = rnd_inexact;
                flags_d[FLAG_OVERFLOW] = rnd_ovf;
`endif
            end
            ST_DONE: begin
                // out_valid rises one cycle after result_q is loaded
                if (!valid_q) begin
                    valid_d = 1'b1;
                end else if (out_ready) begin
                    valid_d = 1'b0;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            sign_q   <= 1'b0;
            exp_q    <= '0;
            mant_q   <= '0;
            g_q      <= 1'b0;
            r_q      <= 1'b0;
            s_q      <= 1'b0;
            cnt_q    <= '0;
            result_q <= '0;
            valid_q  <= 1'b0;
`ifdef FP_NORM_STATUS_EN
            flags_q  <= '0;
`endif
        end else begin
            state_q  <= state_d;
            sign_q   <= sign_d;
            exp_q    <= exp_d;
            mant_q   <= mant_d;
            g_q      <= g_d;
            r_q      <= r_d;
            s_q      <= s_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
            valid_q  <= valid_d;
`ifdef FP_NORM_STATUS_EN
            flags_q  <= flags_d;
`endif
        end
    end

endmodule

// File: doc/fp_normalize_round.md
Name: fp_normalize_round

Overview:
- Downstream stage of the single-precision magnitude adder.
- Accepts the raw sum from the adder: sign, maximum exponent, 25-bit mantissa including the carry bit, and guard/round/sticky bits.
- Normalises the sum iteratively, one bit per cycle; rounds to nearest even; packs an IEEE-754 binary32 word.
- Valid/ready handshake on both sides; one operation in flight at a time.

Parameters:
- EXP_W, 8, exponent field width.
- FRAC_W, 23, stored fraction width. Mantissa input width is FRAC_W+2.
- MAX_SHIFT, 23, bound on left-shift iterations. Also sizes the shift counter.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, synchronous, active-high.
- in_valid  in  1  upstream sum valid.
- in_ready  out  1  stage can accept; equals (state==IDLE) & ~rst.
- in_sign  in  1  sign of sum.
- in_exp  in  EXP_W  biased exponent (the adder's max exponent).
- in_mant  in  FRAC_W+2  bit 24 = carry, bit 23 = hidden, bits 22:0 = fraction.
- in_grs  in  3  guard, round, sticky bits from alignment.
- out_valid  out  1  result valid; held until accepted.
- out_ready  in  1  downstream accepts.
- out_result  out  32  packed {sign, exp, frac}.

Behaviour:
- Reset: state IDLE; out_valid=0; out_result=0; all internal registers cleared. Reset aborts any operation in flight, in any state.
- FSM states: IDLE, CHECK, SHIFT, ROUND, DONE.
- IDLE: capture all inputs on in_valid & in_ready, then go to CHECK.
- CHECK, tested in this order:
  - in_exp==255 → result {sign, 8'hFF, 0} (infinity passthrough) → DONE.
  - mant==0 && grs==0 → signed zero → DONE.
  - mant[24]==1 → right-shift 1, exp+1, new G=mant[0], R=old G, S=old R|old S → ROUND.
  - mant[23]==1 → ROUND.
  - Otherwise → SHIFT.
- SHIFT, one step per cycle: mant<<1 with mant[0]=G, G=R, R=0, S unchanged, exp-1.
  - Go to ROUND when mant[23]==1.
  - If exp would reach 0 before mant[23] is set: flush to signed zero → DONE.
  - Counter exceeding MAX_SHIFT is unreachable; treat it as flush to zero.
- ROUND (RNE): increment mant when G & (R | S | mant[0]).
  - Increment overflow (24'hFFFFFF+1): mant=24'h800000, exp+1.
  - exp>=255 after this step → infinity {sign, 8'hFF, 0}.
  - Register out_result → DONE.
- DONE: out_valid=1 and out_result stable until out_ready; on handshake go to IDLE (out_valid=0 next cycle). No overlap: a new input is accepted no earlier than the cycle after the output handshake.
- Latency from accept edge to out_valid:
  - Normalised or carry input: 3 cycles.
  - k left shifts: 3+k cycles.
  - Zero or infinity: 2 cycles.
- Arithmetic width: exponent is held internally as EXP_W+1 bits so overflow detection does not wrap.
- Inputs are ignored outside IDLE.

Optional Feature:
- Macro FP_NORM_STATUS_EN.
- Defined: adds port out_flags out 4 = {inexact, overflow, underflow, zero}, registered with out_result and valid with out_valid. Reset value 0.
  - inexact = any G/R/S nonzero at ROUND.
  - overflow = result forced to infinity by rounding or exponent carry (not infinity passthrough).
  - underflow = flush to zero.
  - zero = result magnitude zero.
- Undefined: port and flag logic absent; all other behaviour identical.

Decomposition:
- Package fp_norm_pkg:
  - FSM state enum.
  - EXP_MAX=255, BIAS=127, EXP_W/FRAC_W constants.
  - Flag-bit index constants.
- One combinational sub-module, fp_round_rne:
  - Inputs: 24-bit mant, G, R, S, exp.
  - Outputs: rounded mant, exp, overflow, inexact.
  - Instantiated in the ROUND state path.

Test Plan:
- Carry path: in_exp=8'h80, in_mant=25'h1800000, grs=0 → out_result=32'h40C00000 (6.0), out_valid 3 cycles after accept.
- Left shift: in_exp=8'h7F, in_mant=25'h0200000, grs=0 → 2 SHIFT cycles, out_result=32'h3E800000 (0.25), out_valid 5 cycles after accept.
- RNE tie: in_exp=8'h7F, mant=25'h0800001, grs=3'b100 → 32'h3F800002; same with mant=25'h0800000 → 32'h3F800000.
- Overflow: in_exp=8'hFE, mant=25'h1FFFFFE, grs=0 → 32'h7F800000. With FP_NORM_STATUS_EN, out_flags overflow=1.
- Zero and underflow:
  - mant=0, grs=0, sign=1 → 32'h80000000 after 2 cycles.
  - in_exp=8'h01, mant=25'h0400000 → 32'h00000000; underflow flag set when enabled.
- Backpressure and reset:
  - Hold out_ready=0 for 10 cycles → out_result stable, in_ready=0; then out_ready=1 → in_ready=1 the next cycle.
  - Assert rst during SHIFT → next cycle out_valid=0, state IDLE; in_ready=1 once rst deasserts.
